// File: rtl/iir_mc.sv
// Multi-channel first-order IIR: y = (state >> SHIFT) + (x << GAIN), one state per channel.
// Optional output saturation enabled by defining IIR_MC_SAT_EN (default build wraps).
module iir_mc #(
  parameter int XW    = 8,
  parameter int YW    = 10,
  parameter int CH    = 4,
  parameter int SHIFT = 1,
  parameter int GAIN  = 2,
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [XW-1:0]  in_x,
  input  logic           in_clr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_ch,
  output logic [YW-1:0]  out_y
);

  if (YW < XW + GAIN || SHIFT < 1 || SHIFT > YW - 1 || CH < 1) begin : g_bad_params
    $error("iir_mc: illegal parameter combination");
  end

  logic [YW-1:0]  state_reg [CH];
  logic [CH-1:0]  wr_en;
  logic           out_valid_reg;
  logic [CHW-1:0] out_ch_reg;
  logic [YW-1:0]  out_y_reg;

  logic           accept;
  logic           ch_ok;
  logic           take;
  logic [YW-1:0]  prev;
  logic [YW-1:0]  result;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign ch_ok    = 32'(in_ch) < CH;
  // Out-of-range channels are accepted (handshake unaffected) but otherwise dropped.
  assign take     = accept && ch_ok;

  always_comb begin
    prev = '0;
    for (int i = 0; i < CH; i++) begin
      if (in_ch == CHW'(i)) prev = state_reg[i];
    end
    if (in_clr) prev = '0;
  end

`ifdef IIR_MC_SAT_EN
  logic [YW:0] sum;
  assign sum    = ({1'b0, prev} >> SHIFT) + ((YW+1)'(in_x) << GAIN);
  assign result = sum[YW] ? {YW{1'b1}} : sum[YW-1:0];
`else
  logic [YW-1:0] sum;
  assign sum    = (prev >> SHIFT) + (YW'(in_x) << GAIN);
  assign result = sum;
`endif

  for (genvar gi = 0; gi < CH; gi++) begin : g_wr
    assign wr_en[gi] = take && (in_ch == CHW'(gi));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CH; i++) state_reg[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (wr_en[i]) state_reg[i] <= result;
      end
    end
  end

  // Single output register: a new sample replaces the one being consumed in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      out_y_reg     <= '0;
    end else if (take) begin
      out_valid_reg <= 1'b1;
      out_ch_reg    <= in_ch;
      out_y_reg     <= result;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_ch    = out_ch_reg;
  assign out_y     = out_y_reg;

endmodule

// File: tb/tb_iir_mc.sv
// Testbench for iir_mc: vector table, interleave/stall and reset sequences, random traffic vs model.
module tb_iir_mc;
  localparam int XW    = 8;
  localparam int YW    = 10;
  localparam int CH    = 4;
  localparam int SHIFT = 1;
  localparam int GAIN  = 2;
  localparam int CHW   = 2;
  localparam int YMAX  = (1 << YW) - 1;
`ifdef IIR_MC_SAT_EN
  localparam int SAT_CASE = 1023;
  localparam bit SAT_ON   = 1'b1;
`else
  localparam int SAT_CASE = 506;
  localparam bit SAT_ON   = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [CHW-1:0] in_ch;
  logic [XW-1:0]  in_x;
  logic           in_clr;
  logic           out_valid;
  logic           out_ready;
  logic [CHW-1:0] out_ch;
  logic [YW-1:0]  out_y;

  iir_mc #(.XW(XW), .YW(YW), .CH(CH), .SHIFT(SHIFT), .GAIN(GAIN)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_x(in_x), .in_clr(in_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_y(out_y)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: per-channel state plus the one pending output.
  int m_st [CH];
  bit m_v;
  int m_ch;
  int m_y;

  int rx_ch[$];
  int rx_y[$];

  typedef struct {
    int ch;
    int x;
    bit clr;
    int exp_y;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < CH; i++) m_st[i] = 0;
    m_v  = 1'b0;
    m_ch = 0;
    m_y  = 0;
  endfunction

  function automatic int filt(input int prev, input int x);
    int s;
    s = prev / (2 ** SHIFT) + x * (2 ** GAIN);
    if (s > YMAX) s = SAT_ON ? YMAX : s % (YMAX + 1);
    return s;
  endfunction

  function automatic void add_vec(input int ch, input int x, input bit clr, input int exp_y);
    vec_t v;
    v.ch = ch; v.x = x; v.clr = clr; v.exp_y = exp_y;
    vecs.push_back(v);
  endfunction

  // One clock: drive, check in_ready, clock, check outputs against the model.
  task automatic cycle(input bit v, input int ch, input int x, input bit clr, input bit ordy,
                       output bit acc);
    bit m_rdy;
    int prev;
    in_valid  = v;
    in_ch     = ch[CHW-1:0];
    in_x      = x[XW-1:0];
    in_clr    = clr;
    out_ready = ordy;
    #1;
    m_rdy = !m_v || ordy;
    chk("in_ready", int'(in_ready), int'(m_rdy));
    if (out_valid && out_ready) begin
      rx_ch.push_back(int'(out_ch));
      rx_y.push_back(int'(out_y));
    end
    acc = v && m_rdy;
    @(posedge clk);
    #1;
    if (acc && ch < CH) begin
      prev     = clr ? 0 : m_st[ch];
      m_st[ch] = filt(prev, x);
      m_v      = 1'b1;
      m_ch     = ch;
      m_y      = m_st[ch];
      $display("txn ch=%0d x=%0d clr=%0d -> y=%0d (dut ch=%0d y=%0d)", ch, x, clr, m_y,
               out_ch, out_y);
    end else if (ordy) begin
      m_v = 1'b0;
    end
    chk("out_valid", int'(out_valid), int'(m_v));
    if (m_v) begin
      chk("out_ch", int'(out_ch), m_ch);
      chk("out_y", int'(out_y), m_y);
    end
  endtask

  initial begin
    bit acc;
    int imp[5];
    int cyc;
    int q_ch[$];
    int q_x[$];
    int q_clr[$];

    imp = '{508, 254, 127, 63, 31};

    // Impulse on ch0.
    add_vec(0, 127, 0, 508);
    add_vec(0, 0, 0, 254); add_vec(0, 0, 0, 127); add_vec(0, 0, 0, 63);
    add_vec(0, 0, 0, 31);  add_vec(0, 0, 0, 15);  add_vec(0, 0, 0, 7);
    add_vec(0, 0, 0, 3);   add_vec(0, 0, 0, 1);   add_vec(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add_vec(0, 0, 0, 0);
    // Step on ch1 converges to 1015 = 508 + floor(1015/2).
    add_vec(1, 127, 0, 508);  add_vec(1, 127, 0, 762);  add_vec(1, 127, 0, 889);
    add_vec(1, 127, 0, 952);  add_vec(1, 127, 0, 984);  add_vec(1, 127, 0, 1000);
    add_vec(1, 127, 0, 1008); add_vec(1, 127, 0, 1012); add_vec(1, 127, 0, 1014);
    add_vec(1, 127, 0, 1015); add_vec(1, 127, 0, 1015);
    // Other channels untouched.
    add_vec(0, 0, 0, 0); add_vec(2, 0, 0, 0); add_vec(3, 0, 0, 0);
    // Overflow on ch2.
    add_vec(2, 255, 0, 1020); add_vec(2, 255, 0, SAT_CASE);
    // Clear on ch3.
    add_vec(3, 127, 0, 508); add_vec(3, 10, 1, 40); add_vec(3, 0, 0, 20);

    reset = 1'b0; in_valid = 1'b0; in_ch = '0; in_x = '0; in_clr = 1'b0; out_ready = 1'b1;
    m_reset();
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_y", int'(out_y), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    reset = 1'b1;

    // Table vectors; the first accept lands on the first edge after release.
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].ch, vecs[i].x, vecs[i].clr, 1'b1, acc);
      chk("vec_y", int'(out_y), vecs[i].exp_y);
    end

    // in_clr without in_valid leaves ch3 at 20.
    cycle(1'b0, 3, 0, 1'b1, 1'b1, acc);
    cycle(1'b1, 3, 0, 1'b0, 1'b1, acc);
    chk("clr_no_valid", int'(out_y), 10);

    // Interleaved impulses with a 3-cycle downstream stall.
    cycle(1'b0, 0, 0, 1'b0, 1'b1, acc);
    rx_ch.delete();
    rx_y.delete();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < CH; c++) begin
        q_ch.push_back(c);
        q_x.push_back(r == 0 ? 127 : 0);
        q_clr.push_back(r == 0 ? 1 : 0);
      end
    end
    cyc = 0;
    while (q_ch.size() > 0 && cyc < 200) begin
      cycle(1'b1, q_ch[0], q_x[0], q_clr[0] != 0, !(cyc >= 6 && cyc < 9), acc);
      if (acc) begin
        void'(q_ch.pop_front());
        void'(q_x.pop_front());
        void'(q_clr.pop_front());
      end
      cyc++;
    end
    chk("ilv_leftover", q_ch.size(), 0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, acc);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, acc);
    chk("ilv_count", rx_y.size(), 20);
    for (int c = 0; c < CH; c++) begin
      int k;
      k = 0;
      foreach (rx_ch[i]) begin
        if (rx_ch[i] == c) begin
          if (k < 5) chk("ilv_seq", rx_y[i], imp[k]);
          k++;
        end
      end
      chk("ilv_per_ch", k, 5);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, CH - 1)),
            int'($urandom_range(0, 255)), $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0, acc);
    end

    // Reset mid-cycle with a stalled output pending.
    cycle(1'b1, 1, 100, 1'b0, 1'b0, acc);
    chk("pre_rst_valid", int'(out_valid), 1);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_y", int'(out_y), 0);
    chk("async_rst_ch", int'(out_ch), 0);
    m_reset();
    @(posedge clk); #1;
    chk("rst_hold_valid", int'(out_valid), 0);
    reset = 1'b1;
    cycle(1'b1, 0, 0, 1'b0, 1'b1, acc);
    chk("post_rst_ch0", int'(out_y), 0);
    chk("post_rst_valid", int'(out_valid), 1);
    cycle(1'b1, 1, 0, 1'b0, 1'b1, acc);
    chk("post_rst_ch1", int'(out_y), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
